pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the Ak-16b core. It produces every control input of the instruction-fetch stage, including stall, flush, halt and the redirect selects and targets. It also produces the matching bubble and hold controls for the IF/ID, ID/EX1 and EX1/EX2 pipeline registers. Its job is to arbitrate the following same-cycle events into one consistent decision per clock: load-use hazards, ID-stage jumps, EX2-stage branches, and HLT/resume. It also keeps saturating stall and flush event counters for debug.

---
 rtl/pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates branch, load-use, jump and halt events into
// one set of fetch-stage and pipeline-register controls per clock, plus debug counters.
module pipe_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex1_mem_read,
   input  logic [2:0]  ex1_rd,
   input  logic [2:0]  id_rs1,
   input  logic [2:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic        id_jump,
   input  logic [15:0] id_jump_target,
   input  logic        id_halt,
   input  logic        ex2_branch,
   input  logic [15:0] ex2_branch_target,
   input  logic        resume,
   output logic        stall_if,
   output logic        flush_if,
   output logic        halt,
   output logic        jump_taken,
   output logic [15:0] jump_target,
   output logic        branch_taken,
   output logic [15:0] branch_target,
   output logic        stall_id,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        flush_ex1ex2,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StDrain  = 2'd1,
      StHalted = 2'd2
   } state_e;

   localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  drain_q, drain_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;
   logic        lu;

   assign lu = ex1_mem_read & ((id_rs1_used & (id_rs1 == ex1_rd)) |
                               (id_rs2_used & (id_rs2 == ex1_rd)));

   always_comb begin
      state_d       = state_q;
      drain_d       = drain_q;
      stall_if      = 1'b0;
      flush_if      = 1'b0;
      halt          = 1'b0;
      jump_taken    = 1'b0;
      branch_taken  = 1'b0;
      stall_id      = 1'b0;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      flush_ex1ex2  = 1'b0;
      jump_target   = id_jump_target;
      branch_target = ex2_branch_target;

      unique case (state_q)
         StRun: begin
            if (ex2_branch) begin
               branch_taken = 1'b1;
               flush_if     = 1'b1;
               flush_ifid   = 1'b1;
               flush_idex   = 1'b1;
               flush_ex1ex2 = 1'b1;
            end else if (lu) begin
               stall_if   = 1'b1;
               stall_id   = 1'b1;
               flush_idex = 1'b1;
            end else if (id_jump) begin
               jump_taken = 1'b1;
               flush_if   = 1'b1;
               flush_ifid = 1'b1;
            end else if (id_halt) begin
               stall_if   = 1'b1;
               flush_ifid = 1'b1;
               state_d    = StDrain;
               drain_d    = DrainLoad;
            end
         end
         StDrain: begin
            // A taken branch outranks the pending halt: redirect instead of freezing the PC.
            if (ex2_branch) begin
               branch_taken = 1'b1;
               flush_if     = 1'b1;
               flush_ifid   = 1'b1;
               flush_idex   = 1'b1;
               flush_ex1ex2 = 1'b1;
               state_d      = StRun;
               drain_d      = 4'd0;
            end else begin
               stall_if   = 1'b1;
               flush_ifid = 1'b1;
               if (drain_q == 4'd0) begin
                  state_d = StHalted;
               end else begin
                  drain_d = drain_q - 4'd1;
               end
            end
         end
         StHalted: begin
            halt       = 1'b1;
            stall_if   = 1'b1;
            flush_ifid = 1'b1;
            if (resume) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StRun;
            drain_d = 4'd0;
         end
      endcase

      stall_cnt_d = stall_cnt_q;
      if (stall_id && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      flush_cnt_d = flush_cnt_q;
      if ((jump_taken || branch_taken) && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StRun;
         drain_q     <= 4'd0;
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus random traffic,
// all outputs compared every cycle against a priority-rule model of the controller.
module tb_pipe_ctrl;

   localparam int DRAIN = 4;

   typedef struct packed {
      logic stall_if, flush_if, halt, jump_taken, branch_taken;
      logic stall_id, flush_ifid, flush_idex, flush_ex1ex2;
   } ctl_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex1_mem_read, id_rs1_used, id_rs2_used, id_jump, id_halt, ex2_branch, resume;
   logic [2:0]  ex1_rd, id_rs1, id_rs2;
   logic [15:0] id_jump_target, ex2_branch_target;
   logic        stall_if, flush_if, halt, jump_taken, branch_taken;
   logic        stall_id, flush_ifid, flush_idex, flush_ex1ex2;
   logic [15:0] jump_target, branch_target, stall_cnt, flush_cnt;
   logic [1:0]  state;

   int nvec = 0;
   int nerr = 0;

   pipe_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
      .clk(clk), .rst(rst),
      .ex1_mem_read(ex1_mem_read), .ex1_rd(ex1_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_jump(id_jump), .id_jump_target(id_jump_target), .id_halt(id_halt),
      .ex2_branch(ex2_branch), .ex2_branch_target(ex2_branch_target), .resume(resume),
      .stall_if(stall_if), .flush_if(flush_if), .halt(halt),
      .jump_taken(jump_taken), .jump_target(jump_target),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .stall_id(stall_id), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .flush_ex1ex2(flush_ex1ex2), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
   );

   always #5 clk = ~clk;

   // Model: mode 0=run, 1=drain, 2=halted; m_left counts drain cycles still to spend.
   int   m_mode = 0, m_left = 0, m_sc = 0, m_fc = 0;
   logic m_lu;
   ctl_t m_ctl, dut_ctl;

   function automatic ctl_t expect_ctl(int mode, logic br, logic luv, logic jmp, logic hlt);
      ctl_t c = '0;
      if (mode == 2) begin
         c.halt = 1; c.stall_if = 1; c.flush_ifid = 1;
      end else if (br) begin
         c.branch_taken = 1; c.flush_if = 1; c.flush_ifid = 1;
         c.flush_idex = 1; c.flush_ex1ex2 = 1;
      end else if (mode == 1) begin
         c.stall_if = 1; c.flush_ifid = 1;
      end else if (luv) begin
         c.stall_if = 1; c.stall_id = 1; c.flush_idex = 1;
      end else if (jmp) begin
         c.jump_taken = 1; c.flush_if = 1; c.flush_ifid = 1;
      end else if (hlt) begin
         c.stall_if = 1; c.flush_ifid = 1;
      end
      return c;
   endfunction

   assign m_lu = ex1_mem_read && ((id_rs1_used && id_rs1 == ex1_rd) ||
                                  (id_rs2_used && id_rs2 == ex1_rd));
   always_comb m_ctl = expect_ctl(m_mode, ex2_branch, m_lu, id_jump, id_halt);
   assign dut_ctl = {stall_if, flush_if, halt, jump_taken, branch_taken,
                     stall_id, flush_ifid, flush_idex, flush_ex1ex2};

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode <= 0; m_left <= 0; m_sc <= 0; m_fc <= 0;
      end else begin
         if (m_mode == 0 && !ex2_branch && m_lu && m_sc < 65535) m_sc <= m_sc + 1;
         if ((m_ctl.jump_taken || m_ctl.branch_taken) && m_fc < 65535) m_fc <= m_fc + 1;
         case (m_mode)
            0: if (!ex2_branch && !m_lu && !id_jump && id_halt) begin
                  m_mode <= 1;
                  m_left <= DRAIN;
               end
            1: if (ex2_branch) m_mode <= 0;
               else begin
                  if (m_left == 1) m_mode <= 2;
                  m_left <= m_left - 1;
               end
            default: if (resume) m_mode <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      nvec++;
      if (dut_ctl !== m_ctl || jump_target !== id_jump_target ||
          branch_target !== ex2_branch_target || state !== 2'(m_mode) ||
          stall_cnt !== 16'(m_sc) || flush_cnt !== 16'(m_fc)) begin
         nerr++;
         $display("FAIL cycle_model t=%0t ctl=%b/%b state=%0d/%0d stall_cnt=%0d/%0d flush_cnt=%0d/%0d jt=%h/%h bt=%h/%h",
                  $time, dut_ctl, m_ctl, state, m_mode, stall_cnt, m_sc, flush_cnt, m_fc,
                  jump_target, id_jump_target, branch_target, ex2_branch_target);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      ex1_mem_read = 0; ex1_rd = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
      id_jump = 0; id_jump_target = 0; id_halt = 0; ex2_branch = 0; ex2_branch_target = 0;
      resume = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      #3;
      chk("reset_ctl", 32'(dut_ctl), 0);
      chk("reset_targets", {jump_target, branch_target}, 0);
      chk("reset_state_cnt", {14'd0, state, stall_cnt}, 0);
      step();
      rst = 1;

      // Load-use on rs2
      ex1_mem_read = 1; ex1_rd = 3; id_rs2 = 3; id_rs2_used = 1;
      #2 chk("lu_stall", {stall_if, stall_id, flush_idex}, 3'b111);
      step(); idle();
      #2 chk("lu_stall_cnt", stall_cnt, 1);
      chk("lu_released", {stall_if, state}, 0);

      // Branch outranks jump
      step();
      ex2_branch = 1; ex2_branch_target = 16'h0040; id_jump = 1; id_jump_target = 16'h0100;
      #2 chk("br_vs_jump", {branch_taken, jump_taken}, 2'b10);
      chk("br_flushes", {flush_if, flush_ifid, flush_idex, flush_ex1ex2}, 4'hF);
      chk("br_target", branch_target, 16'h0040);
      step(); idle();
      #2 chk("br_flush_cnt", flush_cnt, 1);

      // Jump deferred by load-use
      step();
      id_jump = 1; id_jump_target = 16'h0020; ex1_mem_read = 1; ex1_rd = 5;
      id_rs1 = 5; id_rs1_used = 1;
      #2 chk("jump_blocked", {jump_taken, stall_if}, 2'b01);
      step();
      ex1_mem_read = 0;
      #2 chk("jump_later", {jump_taken, jump_target}, {1'b1, 16'h0020});
      step(); idle();
      #2 chk("jump_counts", {stall_cnt, flush_cnt}, {16'd2, 16'd2});

      // Halt, drain, ignore branch while halted, resume
      step();
      id_halt = 1;
      #2 chk("hlt_cycle", {stall_if, flush_ifid, halt}, 3'b110);
      step(); idle();
      for (int i = 0; i < DRAIN; i++) begin
         #2 chk("drain_state", {state, halt}, 3'b010);
         step();
      end
      #2 chk("halted", {state, halt}, 3'b101);
      ex2_branch = 1; ex2_branch_target = 16'h1234;
      #0 chk("halted_br_ignored", {branch_taken, flush_idex}, 0);
      step(); idle();
      #2 chk("still_halted", state, 2);
      resume = 1;
      step(); resume = 0;
      #2 chk("resumed", {state, halt, stall_if}, 0);

      // Halt cancelled by branch on 2nd drain cycle
      step(); id_halt = 1;
      step(); idle();
      #2 chk("cancel_drain1", state, 1);
      step();
      ex2_branch = 1; ex2_branch_target = 16'h0080;
      #2 chk("cancel_br", {branch_taken, halt, stall_if}, 3'b100);
      step(); idle();
      #2 chk("cancel_run", {state, halt}, 0);

      // Async reset in the middle of drain
      step(); id_halt = 1;
      step(); idle();
      step();
      #1 rst = 0;
      #1 chk("rst_mid_drain", {state, stall_cnt, flush_cnt}, 0);
      step(); rst = 1;

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         step();
         ex1_mem_read = ($urandom % 3) == 0;
         ex1_rd = 3'($urandom); id_rs1 = 3'($urandom); id_rs2 = 3'($urandom);
         id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
         id_jump = ($urandom % 4) == 0; id_jump_target = 16'($urandom);
         id_halt = ($urandom % 8) == 0;
         ex2_branch = ($urandom % 6) == 0; ex2_branch_target = 16'($urandom);
         resume = ($urandom % 5) == 0;
      end
      step(); idle();

      // Saturate the stall counter
      rst = 0;
      step(); rst = 1;
      ex1_mem_read = 1; ex1_rd = 6; id_rs1 = 6; id_rs1_used = 1;
      repeat (70000) step();
      #2 chk("stall_sat", {stall_cnt, flush_cnt}, {16'hFFFF, 16'd0});
      idle();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
